// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage between IF/ID and EX.
//
// Decodes a 16-bit instruction ([15:12] opcode, [11:8] rd, [7:4] rs,
// [3:0] rt/imm4). It drives the register-file read ports and forwards the
// write-back data when the write targets a register being read in the same
// cycle. It detects load-use hazards, inserts bubbles and stalls fetch, and
// registers the operands, immediate, destination and control into ID/EX.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_if, npc_if, valid_if  instruction, PC+1 and valid flag from IF/ID
//   flush                      kill the instruction being decoded
//   hold_ex                    EX cannot accept; freeze ID/EX
//   read_index_1/2             register-file read addresses (combinational)
//   read_data_1/2              register-file read data (combinational)
//   wb_we, wb_idx, wb_data     write-back port, used for the same-cycle bypass
//   stall_if                   fetch must hold PC and IF/ID (combinational)
//   *_id                       ID/EX pipeline register outputs
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       inst_if,
    input  logic [15:0]       npc_if,
    input  logic              valid_if,
    input  logic              flush,
    input  logic              hold_ex,
    output logic [IDX_W-1:0]  read_index_1,
    output logic [IDX_W-1:0]  read_index_2,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_if,
    output logic              valid_id,
    output logic [15:0]       npc_id,
    output logic [DATA_W-1:0] op_a_id,
    output logic [DATA_W-1:0] op_b_id,
    output logic [15:0]       imm_id,
    output logic [IDX_W-1:0]  rd_id,
    output logic [2:0]        alu_op_id,
    output logic              reg_write_id,
    output logic              mem_read_id,
    output logic              mem_write_id,
    output logic              branch_id,
    output logic              jump_id,
    output logic              imm_sel_id,
    output logic              illegal_id
);

    typedef struct packed {
        logic              valid;
        logic [15:0]       npc;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [15:0]       imm;
        logic [IDX_W-1:0]  rd;
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              imm_sel;
        logic              illegal;
    } idex_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_PSB = 3'd4;

    idex_t idex_q, idex_d, dec;

    logic [3:0]       opc;
    logic [IDX_W-1:0] rd_f, rs_f, rt_f;
    logic             use_1, use_2, hazard;

    // 4-bit register fields are zero-extended into the wider index space.
    assign opc  = inst_if[15:12];
    assign rd_f = IDX_W'(inst_if[11:8]);
    assign rs_f = IDX_W'(inst_if[7:4]);
    assign rt_f = IDX_W'(inst_if[3:0]);

    // ST reads rd as store data and BEQ compares rd with rs, so both use rd on port 2.
    assign read_index_1 = rs_f;
    assign read_index_2 = (opc == 4'h7 || opc == 4'h8) ? rd_f : rt_f;

    // Only ports the opcode really reads can create a load-use hazard.
    always_comb begin
        use_1 = 1'b0;
        use_2 = 1'b0;
        case (opc)
            4'h1, 4'h2, 4'h3, 4'h4: begin use_1 = 1'b1; use_2 = 1'b1; end
            4'h5, 4'h6:             use_1 = 1'b1;
            4'h7, 4'h8:             begin use_1 = 1'b1; use_2 = 1'b1; end
            default:                ;
        endcase
    end

    assign hazard = valid_if & idex_q.valid & idex_q.mem_read & (idex_q.rd != '0) &
                    ((use_1 & (read_index_1 == idex_q.rd)) |
                     (use_2 & (read_index_2 == idex_q.rd)));

    assign stall_if = hold_ex | (hazard & ~flush);

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.npc   = npc_if;

        // r0 is hard zero; otherwise a same-cycle write-back beats the stale read.
        if (read_index_1 == '0)                   dec.op_a = '0;
        else if (wb_we && wb_idx == read_index_1) dec.op_a = wb_data;
        else                                      dec.op_a = read_data_1;
        if (read_index_2 == '0)                   dec.op_b = '0;
        else if (wb_we && wb_idx == read_index_2) dec.op_b = wb_data;
        else                                      dec.op_b = read_data_2;

        dec.imm = {{12{inst_if[3]}}, inst_if[3:0]};
        dec.rd  = rd_f;
        case (opc)
            4'h1: begin dec.alu_op = ALU_ADD; dec.reg_write = 1'b1; end
            4'h2: begin dec.alu_op = ALU_SUB; dec.reg_write = 1'b1; end
            4'h3: begin dec.alu_op = ALU_AND; dec.reg_write = 1'b1; end
            4'h4: begin dec.alu_op = ALU_OR;  dec.reg_write = 1'b1; end
            4'h5: begin dec.reg_write = 1'b1; dec.imm_sel = 1'b1; end
            4'h6: begin dec.reg_write = 1'b1; dec.imm_sel = 1'b1; dec.mem_read = 1'b1; end
            4'h7: begin dec.imm_sel = 1'b1; dec.mem_write = 1'b1; end
            4'h8: begin dec.alu_op = ALU_SUB; dec.branch = 1'b1; end
            4'h9: begin dec.jump = 1'b1; dec.imm = {{4{inst_if[11]}}, inst_if[11:0]}; end
            4'hA: begin
                dec.alu_op    = ALU_PSB;
                dec.reg_write = 1'b1;
                dec.imm_sel   = 1'b1;
                dec.imm       = {inst_if[7:0], 8'h00};
            end
            4'h0: begin dec.imm = '0; dec.rd = '0; end
            default: begin
                // Undefined opcodes travel as NOPs that carry the illegal flag.
                dec.imm     = '0;
                dec.rd      = '0;
                dec.illegal = 1'b1;
            end
        endcase
        if (rd_f == '0) dec.reg_write = 1'b0;
    end

    // flush outranks hold_ex so a squashed instruction is never kept alive.
    always_comb begin
        idex_d = idex_q;
        if (flush)                    idex_d = '0;
        else if (hold_ex)             idex_d = idex_q;
        else if (hazard || !valid_if) idex_d = '0;
        else                          idex_d = dec;
    end

    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign valid_id     = idex_q.valid;
    assign npc_id       = idex_q.npc;
    assign op_a_id      = idex_q.op_a;
    assign op_b_id      = idex_q.op_b;
    assign imm_id       = idex_q.imm;
    assign rd_id        = idex_q.rd;
    assign alu_op_id    = idex_q.alu_op;
    assign reg_write_id = idex_q.reg_write;
    assign mem_read_id  = idex_q.mem_read;
    assign mem_write_id = idex_q.mem_write;
    assign branch_id    = idex_q.branch;
    assign jump_id      = idex_q.jump;
    assign imm_sel_id   = idex_q.imm_sel;
    assign illegal_id   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a small register-file array answers the
// read ports, and every expected value below is worked out by hand.
module tb_decode_stage;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       inst_if, npc_if;
    logic              valid_if, flush, hold_ex;
    logic [IDX_W-1:0]  read_index_1, read_index_2;
    logic [DATA_W-1:0] read_data_1, read_data_2;
    logic              wb_we;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic              stall_if, valid_id;
    logic [15:0]       npc_id, imm_id;
    logic [DATA_W-1:0] op_a_id, op_b_id;
    logic [IDX_W-1:0]  rd_id;
    logic [2:0]        alu_op_id;
    logic reg_write_id, mem_read_id, mem_write_id, branch_id, jump_id, imm_sel_id, illegal_id;

    logic [DATA_W-1:0] rf [0:31];
    int n_cmp = 0;
    int n_err = 0;

    assign read_data_1 = rf[read_index_1];
    assign read_data_2 = rf[read_index_2];

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .inst_if(inst_if), .npc_if(npc_if),
        .valid_if(valid_if), .flush(flush), .hold_ex(hold_ex),
        .read_index_1(read_index_1), .read_index_2(read_index_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
        .stall_if(stall_if), .valid_id(valid_id), .npc_id(npc_id),
        .op_a_id(op_a_id), .op_b_id(op_b_id), .imm_id(imm_id), .rd_id(rd_id),
        .alu_op_id(alu_op_id), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
        .branch_id(branch_id), .jump_id(jump_id), .imm_sel_id(imm_sel_id),
        .illegal_id(illegal_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Registered outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1; inst_if = '0; npc_if = '0; valid_if = 1'b0;
        flush = 1'b0; hold_ex = 1'b0; wb_we = 1'b0; wb_idx = '0; wb_data = '0;
        tick(); tick();
        chk("rst_valid", valid_id, 0);
        chk("rst_stall", stall_if, 0);
        chk("rst_opa",   op_a_id, 0);
        chk("rst_rd",    rd_id, 0);
        reset = 1'b0;

        // 1: ADD r3,r1,r2
        rf[1] = 16'd5; rf[2] = 16'd7;
        inst_if = 16'h1312; npc_if = 16'd1; valid_if = 1'b1;
        settle();
        chk("add_stall", stall_if, 0);
        tick();
        chk("add_valid", valid_id, 1);
        chk("add_opa",   op_a_id, 5);
        chk("add_opb",   op_b_id, 7);
        chk("add_rd",    rd_id, 3);
        chk("add_alu",   alu_op_id, 0);
        chk("add_rw",    reg_write_id, 1);
        chk("add_npc",   npc_id, 1);

        // 2: LD r4,[r1+2] then ADD r5,r4,r1 -> one bubble
        rf[4] = 16'd9;
        inst_if = 16'h6412; npc_if = 16'd2;
        tick();
        chk("ld_valid", valid_id, 1);
        chk("ld_mr",    mem_read_id, 1);
        chk("ld_rd",    rd_id, 4);
        chk("ld_imm",   imm_id, 16'h0002);
        chk("ld_isel",  imm_sel_id, 1);
        inst_if = 16'h1541; npc_if = 16'd3;
        settle();
        chk("lu_stall", stall_if, 1);
        tick();
        chk("lu_bubble_valid", valid_id, 0);
        chk("lu_bubble_rw",    reg_write_id, 0);
        chk("lu_bubble_mr",    mem_read_id, 0);
        settle();
        chk("lu_stall_gone", stall_if, 0);
        tick();
        chk("lu_add_valid", valid_id, 1);
        chk("lu_add_rd",    rd_id, 5);
        chk("lu_add_opa",   op_a_id, 9);
        chk("lu_add_opb",   op_b_id, 5);
        chk("lu_add_npc",   npc_id, 3);

        // 3: ADDI r2,r1,-1 with write-back bypass of r1
        rf[1] = '0;
        inst_if = 16'h521F; npc_if = 16'd4;
        wb_we = 1'b1; wb_idx = 5'd1; wb_data = 16'h00AA;
        tick();
        chk("byp_opa",  op_a_id, 16'h00AA);
        chk("byp_imm",  imm_id, 16'hFFFF);
        chk("byp_isel", imm_sel_id, 1);
        chk("byp_rd",   rd_id, 2);
        wb_we = 1'b0;

        // 4: flush + hold_ex + hazard together
        inst_if = 16'h6412; npc_if = 16'd5;
        tick();
        inst_if = 16'h1541; flush = 1'b1; hold_ex = 1'b1;
        settle();
        chk("fh_stall", stall_if, 1);
        tick();
        chk("fh_valid", valid_id, 0);
        chk("fh_mr",    mem_read_id, 0);
        flush = 1'b0; hold_ex = 1'b0; inst_if = 16'h4312; npc_if = 16'd9;
        settle();
        chk("fh_stall_gone", stall_if, 0);
        tick();
        chk("fh_next_valid", valid_id, 1);
        chk("fh_next_alu",   alu_op_id, 3);
        chk("fh_next_opb",   op_b_id, 7);

        // 5: illegal opcode, rd=r0, r0 read
        inst_if = 16'hC123;
        tick();
        chk("ill_flag", illegal_id, 1);
        chk("ill_rw",   reg_write_id, 0);
        chk("ill_mw",   mem_write_id, 0);
        inst_if = 16'h1012;
        tick();
        chk("r0dst_rw", reg_write_id, 0);
        chk("r0dst_ill", illegal_id, 0);
        rf[0] = 16'h1234;
        inst_if = 16'h1302;
        tick();
        chk("r0src_opa", op_a_id, 0);
        chk("r0src_opb", op_b_id, 7);

        // 6: ST r3,[r1+2] held three cycles
        rf[3] = 16'h0033;
        inst_if = 16'h7312; npc_if = 16'd12;
        tick();
        chk("st_mw",  mem_write_id, 1);
        chk("st_opb", op_b_id, 16'h0033);
        chk("st_rw",  reg_write_id, 0);
        inst_if = 16'h2312; npc_if = 16'd13; hold_ex = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("hold_stall", stall_if, 1);
            tick();
            chk("hold_valid", valid_id, 1);
            chk("hold_mw",    mem_write_id, 1);
            chk("hold_opb",   op_b_id, 16'h0033);
            chk("hold_npc",   npc_id, 12);
        end
        hold_ex = 1'b0;
        tick();
        chk("rel_alu", alu_op_id, 1);
        chk("rel_mw",  mem_write_id, 0);
        chk("rel_npc", npc_id, 13);

        // JMP, LUI, BEQ and a valid_if=0 bubble
        inst_if = 16'h9FFE;
        tick();
        chk("jmp_imm", imm_id, 16'hFFFE);
        chk("jmp_j",   jump_id, 1);
        chk("jmp_rw",  reg_write_id, 0);
        inst_if = 16'hA3AB;
        tick();
        chk("lui_imm", imm_id, 16'hAB00);
        chk("lui_alu", alu_op_id, 4);
        chk("lui_rw",  reg_write_id, 1);
        inst_if = 16'h8327;
        tick();
        chk("beq_br",  branch_id, 1);
        chk("beq_opb", op_b_id, 16'h0033);
        chk("beq_imm", imm_id, 16'h0007);
        valid_if = 1'b0;
        tick();
        chk("nv_valid", valid_id, 0);
        chk("nv_br",    branch_id, 0);
        valid_if = 1'b1;

        // reset during a load-use stall
        inst_if = 16'h6412;
        tick();
        inst_if = 16'h1541;
        settle();
        chk("rs_stall_pre", stall_if, 1);
        reset = 1'b1;
        tick();
        chk("rs_valid", valid_id, 0);
        chk("rs_stall", stall_if, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage. Sits between the fetch stage (IF/ID register) and the execute stage.
- Decodes the 16-bit instruction and drives the register-file read ports, with write-back bypass.
- Detects load-use hazards, inserts bubbles and stalls fetch.
- Registers operands, immediate, destination and control into the ID/EX pipeline register.

Parameters:
- DATA_W, 16, register/operand width.
- IDX_W, 5, register-file index width; instruction fields are 4 bits, zero-extended (bit 4 always 0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- inst_if  in  16  instruction from the IF/ID register.
- npc_if  in  16  PC+1 of inst_if.
- valid_if  in  1  inst_if is a real instruction.
- flush  in  1  branch/jump taken in EX; kill the instruction being decoded.
- hold_ex  in  1  EX cannot accept; freeze the ID/EX register.
- read_index_1 / read_index_2  out  IDX_W  register-file read addresses (combinational).
- read_data_1 / read_data_2  in  DATA_W  register-file read data (combinational).
- wb_we  in  1  write-back enable.
- wb_idx  in  IDX_W  write-back register index.
- wb_data  in  DATA_W  write-back data.
- stall_if  out  1  fetch must hold PC and the IF/ID register (combinational).
- valid_id  out  1  the ID/EX register holds a live instruction.
- npc_id  out  16  registered npc.
- op_a_id / op_b_id  out  DATA_W  registered source operands.
- imm_id  out  16  registered immediate.
- rd_id  out  IDX_W  registered destination index.
- alu_op_id  out  3  ALU function: 0 add, 1 sub, 2 and, 3 or, 4 pass-B.
- reg_write_id, mem_read_id, mem_write_id, branch_id, jump_id, imm_sel_id  out  1 each  control bits.
- illegal_id  out  1  registered flag: decoded opcode was undefined.

Behaviour:
- Encoding: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt or imm4.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd = rs op rt.
  - 5 ADDI: rd = rs + sext(imm4).
  - 6 LD: rd = mem[rs + sext(imm4)].
  - 7 ST: mem[rs + sext(imm4)] = R[rd].
  - 8 BEQ: compare rd and rs; offset sext(imm4).
  - 9 JMP: imm_id = sext([11:0]).
  - A LUI: rd = {[7:0], 8'h00}; imm_id holds that value; alu_op pass-B.
  - B-F: illegal; decode as NOP with illegal_id=1.
- Read ports:
  - read_index_1 = rs for all opcodes.
  - read_index_2 = rd for ST and BEQ; rt otherwise.
- Operand selection:
  - Index 0 reads as 0 regardless of read_data.
  - Otherwise, if wb_we and wb_idx equals the read index and is nonzero, the operand is wb_data (same-cycle bypass).
  - Otherwise the operand is read_data.
- Destination: reg_write_id = 0 when rd = 0, and for ST, BEQ, JMP, NOP and illegal opcodes.
- imm_sel_id = 1 for ADDI, LD, ST, LUI.
- hazard (combinational) = valid_if & valid_id & mem_read_id & (rd_id != 0) & (rd_id equals any index the incoming instruction actually reads).
- stall_if = hold_ex | (hazard & ~flush).
- ID/EX register update on each rising clk, in priority order:
  1. reset: every output register is 0, including valid_id.
  2. flush: valid_id <= 0 and all control bits <= 0; data fields are don't-care but are forced to 0.
  3. hold_ex: all registers hold their value.
  4. hazard: bubble; valid_id <= 0, control bits <= 0. IF holds, so the same instruction is re-decoded next cycle.
  5. valid_if = 0: bubble as in 4.
  6. Otherwise: load the decoded values, valid_id <= 1.
- Latency: 1 cycle from inst_if to the ID/EX outputs. A load-use hazard costs exactly 1 bubble.
- A bubble always has reg_write, mem_read, mem_write, branch, jump and illegal all 0.
- flush together with hold_ex: flush wins; the squashed register must not be held.
- reset asserted mid-stall: the next cycle has valid_id=0 and stall_if=hold_ex only.
- Immediate arithmetic: sign-extension from bit 3 (imm4) or bit 11 (JMP) to 16 bits; no truncation of DATA_W operands.

Test Plan:
1. Reset, then inst_if=16'h1312 (ADD r3,r1,r2), valid_if=1, R1=5, R2=7 -> next cycle valid_id=1, op_a_id=5, op_b_id=7, rd_id=3, alu_op_id=0, reg_write_id=1.
2. LD r4,[r1+2] (16'h6412), then ADD r5,r4,r1 (16'h1541) -> stall_if=1 for one cycle, one bubble (valid_id=0), then ADD issues with a valid_id pulse; fetch PC held exactly 1 cycle.
3. ADDI r2,r1,-1 (16'h521F) with wb_we=1, wb_idx=1, wb_data=16'h00AA while R1 still reads 0 -> op_a_id=16'h00AA, imm_id=16'hFFFF.
4. flush=1 together with hold_ex=1 and a hazard present -> valid_id=0, stall_if=1 (from hold_ex); next cycle with flush=0 and hold_ex=0, the next instruction loads normally.
5. inst_if=16'hC123 -> illegal_id=1, reg_write_id=0, mem_write_id=0. ADD r0,r1,r2 -> reg_write_id=0. A read of r0 with R0 forced to 16'h1234 -> operand 0.
6. hold_ex=1 for 3 cycles while a valid ST (16'h7312) sits in ID/EX -> outputs stable for all 3 cycles, stall_if=1; release -> the following instruction loads on the next edge.
